// File: rtl/flow_ctrl.sv
// Pipeline flow controller: jump redirect, stall hold and a fixed-length flush, Mealy outputs.
// Optional trap redirect is compiled in with FLOW_CTRL_TRAP_EN (adds trap_req_i / trap_vec_i).
module flow_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_ex_i,
  input  logic        stall_bus_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_flag_o,
  output logic        flush_o
`ifdef FLOW_CTRL_TRAP_EN
  ,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
  localparam logic       FLUSH_AFTER = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        redirect;
  logic [31:0] redirect_addr;

  // Jumps seen during FLUSH are wrong-path and must not redirect.
  always_comb begin
    redirect      = 1'b0;
    redirect_addr = '0;
`ifdef FLOW_CTRL_TRAP_EN
    if (trap_req_i) begin
      redirect      = 1'b1;
      redirect_addr = trap_vec_i;
    end else
`endif
    if (jump_req_i && (state_q != FLUSH)) begin
      redirect      = 1'b1;
      redirect_addr = jump_addr_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    hold_flag_o = 1'b0;
    flush_o     = 1'b0;
    if (!rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (redirect) begin
      jump_en_o   = 1'b1;
      hold_flag_o = 1'b1;
      jump_addr_o = redirect_addr;
      flush_o     = 1'b1;
      state_d     = FLUSH_AFTER ? FLUSH : IDLE;
      cnt_d       = FLUSH_LOAD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stall_ex_i || stall_bus_i) begin
            hold_flag_o = 1'b1;
            state_d     = STALL;
          end
        end
        STALL: begin
          if (stall_ex_i || stall_bus_i) begin
            hold_flag_o = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          // Only a bus wait can hold the PC here; the counter runs regardless.
          flush_o     = 1'b1;
          hold_flag_o = stall_bus_i;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/flow_ctrl.md
FLOW_CTRL -- requirements
Module: flow_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles flush_o is high per taken redirect (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have port jump_req_i, input, 1 bit, the branch/jump-taken request from execute.
REQ-005 SHALL have port jump_addr_i, input, 32 bits, the target for jump_req_i.
REQ-006 SHALL have port stall_ex_i, input, 1 bit, a level-held stall request from a multi-cycle execute unit.
REQ-007 SHALL have port stall_bus_i, input, 1 bit, a level-held stall request from the bus/memory wait.
REQ-008 SHALL have port jump_en_o, output, 1 bit, which loads the PC from jump_addr_o at the next edge.
REQ-009 SHALL have port jump_addr_o, output, 32 bits, the redirect target.
REQ-010 SHALL have port hold_flag_o, output, 1 bit: when high, the PC holds, or loads if jump_en_o is high; when low, the PC increments by 4.
REQ-011 SHALL have port flush_o, output, 1 bit, which kills wrong-path instructions in the IF/ID and ID/EX registers.

Function
REQ-012 SHALL implement three states: IDLE, STALL and FLUSH, plus a 4-bit flush down-counter.
REQ-013 Outputs SHALL be combinational from state and inputs (Mealy), so the redirect takes effect at the same edge as the request (0-cycle latency).
REQ-014 In IDLE with jump_req_i=1, SHALL drive jump_en_o=1, hold_flag_o=1, jump_addr_o=jump_addr_i and flush_o=1, then go to FLUSH with counter=FLUSH_CYCLES-1; if FLUSH_CYCLES=1 it SHALL stay in IDLE.
REQ-015 In IDLE with no jump and (stall_ex_i or stall_bus_i) high, SHALL drive hold_flag_o=1 and jump_en_o=0, then go to STALL.
REQ-016 In IDLE with no requests, all outputs SHALL be 0 and jump_addr_o SHALL be 0.
REQ-017 When a jump and a stall arrive in the same cycle, the jump SHALL win; the stall is re-evaluated after FLUSH because sources hold their request level.
REQ-018 In STALL, hold_flag_o SHALL be high while either stall input is high; when both drop, hold_flag_o SHALL go low in that same cycle and the state returns to IDLE.
REQ-019 In STALL with jump_req_i=1, the jump SHALL be taken exactly as in REQ-014 and the state goes to FLUSH.
REQ-020 In FLUSH, flush_o SHALL be 1 and jump_req_i SHALL be ignored (wrong-path).
REQ-021 In FLUSH, hold_flag_o SHALL equal stall_bus_i, and the counter SHALL decrement every cycle regardless of the stall.
REQ-022 When the counter reaches 0, FLUSH SHALL exit to IDLE, so flush_o is high for exactly FLUSH_CYCLES consecutive cycles.
REQ-023 jump_en_o SHALL never be high without hold_flag_o also being high.

Reset
REQ-024 While rst=0, the state SHALL be IDLE, the counter 0, and all outputs 0 irrespective of the inputs.
REQ-025 A reset asserted mid-FLUSH or mid-STALL SHALL abort immediately; after release the block SHALL behave as from power-up.

Configuration
REQ-026 Macro FLOW_CTRL_TRAP_EN, when defined, SHALL add trap_req_i (1 bit) and trap_vec_i (32 bits).
REQ-027 With FLOW_CTRL_TRAP_EN, a trap SHALL redirect to trap_vec_i as in REQ-014 in any state, including FLUSH (counter reloaded).
REQ-028 With FLOW_CTRL_TRAP_EN, a trap SHALL have priority over jump_req_i and both stalls.
REQ-029 Without FLOW_CTRL_TRAP_EN, the trap ports and logic SHALL be absent.

Verification
REQ-030 Bench SHALL cover a simple jump: IDLE, jump_req_i=1, jump_addr_i=0x0000_0100 for one cycle -> jump_en_o=1, hold_flag_o=1, jump_addr_o=0x100 that cycle; flush_o high for 2 cycles, then IDLE.
REQ-031 Bench SHALL cover a jump during FLUSH: second jump_req_i at 0x200 in the cycle after the first jump -> jump_en_o stays 0, flush_o length unchanged.
REQ-032 Bench SHALL cover a stall: stall_ex_i high for 5 cycles -> hold_flag_o high exactly those 5 cycles and low in the cycle stall_ex_i drops; jump_en_o=0 throughout.
REQ-033 Bench SHALL cover jump plus stall together: jump_req_i and stall_bus_i both high with target 0x40 -> jump taken; after flush, hold_flag_o follows stall_bus_i.
REQ-034 Bench SHALL cover reset mid-operation: rst low during cycle 1 of FLUSH -> all outputs 0 asynchronously; after release, flush_o=0 and state IDLE.
REQ-035 With FLOW_CTRL_TRAP_EN, bench SHALL cover a trap: trap_req_i with trap_vec_i=0x8000_0000 while jump_req_i targets 0x100 -> jump_addr_o=0x8000_0000.
